alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two independent requesters (port 0 and port 1).
- Uses valid/ready handshakes on the request and response sides, with round-robin fairness.
- Latches the winning request's operands and drives the shared ALU from registers.
- Captures the ALU outputs into a response register that is held until consumed.
- Sits between the issue logic of two execution clients and the single ALU instance.

---
 rtl/alu_share_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration with valid/ready on both sides. The winning request
// is latched into registers that drive the ALU. The ALU outputs are captured
// into a response register, which is held until the consumer accepts it.
//
// Optional build macro: ALU_ILLEGAL_OP_CHECK_EN
//   When it is defined, opcodes above 5'd5 are rejected without reaching the
//   ALU. The response then arrives one cycle after accept, with resp_err=1 and
//   zeroed data and flags.
//   When it is undefined, every opcode goes to the ALU and resp_err stays 0.
//
// Handshake rules:
//   - A request transfers on a rising edge where reqN_valid && reqN_ready.
//   - reqN_ready is combinational and is raised for the granted port only.
//   - A response transfers on a rising edge where resp_valid && resp_ready.
//   - resp_* stay stable while resp_valid && !resp_ready.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_opA,
  input  logic [DATA_W-1:0] req0_opB,
  input  logic [4:0]        req0_opcode,
  input  logic [4:0]        req0_shamt,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_opA,
  input  logic [DATA_W-1:0] req1_opB,
  input  logic [4:0]        req1_opcode,
  input  logic [4:0]        req1_shamt,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  output logic [4:0]        alu_opcode,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_isNotEqual,
  input  logic              alu_isLessThan,
  input  logic              alu_overflow,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_ne,
  output logic              resp_lt,
  output logic              resp_ovf,
  output logic              resp_err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               pend_id_q;
  logic [TAG_W-1:0]   pend_tag_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;
  logic [4:0]         alu_op_q;
  logic [4:0]         alu_sh_q;
  logic               resp_valid_q;
  logic               resp_id_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic [DATA_W-1:0]  resp_result_q;
  logic               resp_ne_q;
  logic               resp_lt_q;
  logic               resp_ovf_q;
  logic               resp_err_q;

  logic               can_accept;
  logic               grant_vld;
  logic               grant_id;
  logic               accept;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [4:0]         sel_op;
  logic [4:0]         sel_sh;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_illegal;

  // Arbitration: pick the winner, raise its ready and mux its request fields.
  always_comb begin
    // While reset is held, nothing is accepted.
    can_accept = reset && ((state_q == ST_IDLE) ||
                           ((state_q == ST_RESP) && resp_ready));
    grant_vld  = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    accept     = can_accept && grant_vld;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    sel_a      = grant_id ? req1_opA    : req0_opA;
    sel_b      = grant_id ? req1_opB    : req0_opB;
    sel_op     = grant_id ? req1_opcode : req0_opcode;
    sel_sh     = grant_id ? req1_shamt  : req0_shamt;
    sel_tag    = grant_id ? req1_tag    : req0_tag;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    sel_illegal = (sel_op > 5'd5);
`else
    sel_illegal = 1'b0;
`endif
  end

  // Control FSM: operand latch, one EXEC cycle, then hold the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      pend_id_q     <= 1'b0;
      pend_tag_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_sh_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_tag_q    <= '0;
      resp_result_q <= '0;
      resp_ne_q     <= 1'b0;
      resp_lt_q     <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          resp_valid_q  <= 1'b1;
          resp_id_q     <= pend_id_q;
          resp_tag_q    <= pend_tag_q;
          resp_result_q <= alu_result;
          resp_ne_q     <= alu_isNotEqual;
          resp_lt_q     <= alu_isLessThan;
          resp_ovf_q    <= alu_overflow;
          resp_err_q    <= 1'b0;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: ;
      endcase
      // Accept happens only in IDLE or RESP, so it never overlaps EXEC.
      // When it does happen, it overrides the state chosen above.
      if (accept) begin
        last_grant_q <= grant_id;
        pend_id_q    <= grant_id;
        pend_tag_q   <= sel_tag;
        if (sel_illegal) begin
          // Rejected opcode: answer at once, leave the ALU inputs untouched.
          resp_valid_q  <= 1'b1;
          resp_id_q     <= grant_id;
          resp_tag_q    <= sel_tag;
          resp_result_q <= '0;
          resp_ne_q     <= 1'b0;
          resp_lt_q     <= 1'b0;
          resp_ovf_q    <= 1'b0;
          resp_err_q    <= 1'b1;
          state_q       <= ST_RESP;
        end else begin
          alu_a_q  <= sel_a;
          alu_b_q  <= sel_b;
          alu_op_q <= sel_op;
          alu_sh_q <= sel_sh;
          state_q  <= ST_EXEC;
        end
      end
    end
  end

  assign alu_operandA = alu_a_q;
  assign alu_operandB = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign alu_shamt    = alu_sh_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_tag     = resp_tag_q;
  assign resp_result  = resp_result_q;
  assign resp_ne      = resp_ne_q;
  assign resp_lt      = resp_lt_q;
  assign resp_ovf     = resp_ovf_q;
  assign resp_err     = resp_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: bench for alu_share_arbiter.
// The bench supplies a behavioural stand-in for the ALU. Each accepted request
// is turned into an expected response and pushed onto a queue. A monitor pops
// and compares each response as it is delivered.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [31:0]   acc_cyc;
    logic          id;
    logic [TW-1:0] tag;
    logic [DW-1:0] res;
    logic          ne;
    logic          lt;
    logic          ovf;
    logic          err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic            clock;
  logic            reset;
  logic [1:0]      rv;
  logic [DW-1:0]   ra [2];
  logic [DW-1:0]   rb [2];
  logic [4:0]      rop [2];
  logic [4:0]      rsh [2];
  logic [TW-1:0]   rtag [2];
  logic            rdy0, rdy1;
  logic [1:0]      rdy;
  logic [DW-1:0]   alu_a, alu_b, alu_res;
  logic [4:0]      alu_op, alu_sh;
  logic            alu_ne, alu_lt, alu_ovf;
  logic            resp_valid, resp_ready, resp_id;
  logic [TW-1:0]   resp_tag;
  logic [DW-1:0]   resp_result;
  logic            resp_ne, resp_lt, resp_ovf, resp_err;
  logic [1:0]      dbg_state;

  int              n_vec = 0;
  int              n_fail = 0;
  int unsigned     cyc = 0;
  logic [EXP_W-1:0] exp_q[$];

  assign rdy = {rdy1, rdy0};

  alu_share_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(rdy0), .req0_opA(ra[0]), .req0_opB(rb[0]),
    .req0_opcode(rop[0]), .req0_shamt(rsh[0]), .req0_tag(rtag[0]),
    .req1_valid(rv[1]), .req1_ready(rdy1), .req1_opA(ra[1]), .req1_opB(rb[1]),
    .req1_opcode(rop[1]), .req1_shamt(rsh[1]), .req1_tag(rtag[1]),
    .alu_operandA(alu_a), .alu_operandB(alu_b), .alu_opcode(alu_op), .alu_shamt(alu_sh),
    .alu_result(alu_res), .alu_isNotEqual(alu_ne), .alu_isLessThan(alu_lt),
    .alu_overflow(alu_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result), .resp_ne(resp_ne),
    .resp_lt(resp_lt), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .dbg_state_o(dbg_state)
  );

  // ALU behaviour: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, others give 0.
  function automatic logic [DW+2:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [4:0] op, input logic [4:0] sh);
    logic [DW-1:0] r;
    logic          ovf;
    longint        s;
    r   = '0;
    ovf = 1'b0;
    s   = 0;
    case (op)
      5'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = $signed(a) >>> sh;
      default: r = '0;
    endcase
    return {r, (a != b), ($signed(a) < $signed(b)), ovf};
  endfunction

  assign {alu_res, alu_ne, alu_lt, alu_ovf} = alu_ref(alu_a, alu_b, alu_op, alu_sh);

  function automatic exp_t make_exp(input int unsigned c, input logic id,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [4:0] op, input logic [4:0] sh,
                                    input logic [TW-1:0] tag);
    exp_t            e;
    logic [DW+2:0]   f;
    e.acc_cyc = c;
    e.id      = id;
    e.tag     = tag;
    f = alu_ref(a, b, op, sh);
    {e.res, e.ne, e.lt, e.ovf} = f;
    e.err = 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    if (op > 5'd5) begin
      e.res = '0; e.ne = 1'b0; e.lt = 1'b0; e.ovf = 1'b0; e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Clock and cycle counter.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observer: record accepted requests and check round-robin fairness.
  initial begin : observer
    logic last;
    logic want;
    logic [1:0] stray;
    last = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset) begin
        last = 1'b1;
      end else begin
        check("ready_onehot", rdy0 & rdy1, 0);
        stray = rdy & ~rv;
        check("ready_without_valid", stray, 0);
        for (int p = 0; p < 2; p++) begin
          if (rv[p] && rdy[p]) begin
            if (rv == 2'b11) begin
              want = ~last;
              check("rr_winner", p, want);
            end
            last = p[0];
            exp_q.push_back(make_exp(cyc, p[0], ra[p], rb[p], rop[p], rsh[p], rtag[p]));
          end
        end
      end
    end
  end

  // Monitor: compare each delivered response and check that held responses stay stable.
  initial begin : monitor
    logic        pend;
    logic [40:0] snap, cur, want;
    exp_t        e;
    int unsigned lat;
    pend = 1'b0;
    snap = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        pend = 1'b0;
      end else if (resp_valid) begin
        cur = {resp_id, resp_tag, resp_result, resp_ne, resp_lt, resp_ovf, resp_err};
        if (pend) begin
          check("resp_hold_stable", cur, snap);
        end else begin
          check("resp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_t'(exp_q[0]);
            lat = e.err ? 1 : 2;
            check("resp_latency", cyc - e.acc_cyc, lat);
            want = {e.id, e.tag, e.res, e.ne, e.lt, e.ovf, e.err};
            check("resp_fields", cur, want);
          end
        end
        if (resp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          snap = cur;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] op, input logic [4:0] sh, input logic [TW-1:0] tag);
    ra[p] = a; rb[p] = b; rop[p] = op; rsh[p] = sh; rtag[p] = tag;
    rv[p] = 1'b1;
  endtask

  task automatic wait_accept(input int p, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!(rv[p] && rdy[p]) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, rdy[p], 1);
    step();
    rv[p] = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, resp_valid, 1);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Main stimulus sequence.
  initial begin : main
    int          n;
    int          order[$];
    logic [1:0]  acc;
    rv = 2'b00;
    for (int p = 0; p < 2; p++) begin
      ra[p] = '0; rb[p] = '0; rop[p] = '0; rsh[p] = '0; rtag[p] = '0;
    end
    resp_ready = 1'b0;
    reset = 1'b0;
    rv = 2'b11;
    repeat (2) @(negedge clock);
    // Reset state.
    check("rst_ready", rdy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_sh}, 0);
    check("rst_resp", {resp_id, resp_tag, resp_result, resp_ne, resp_lt, resp_ovf, resp_err}, 0);
    check("rst_state", dbg_state, 0);
    rv = 2'b00;
    step();
    reset = 1'b1;

    // Single add on port 0.
    set_req(0, 32'd5, 32'd7, 5'd0, 5'd0, 4'd3);
    @(negedge clock);
    check("t1_ready0", rdy0, 1);
    check("t1_ready1", rdy1, 0);
    step();
    rv[0] = 1'b0;
    @(negedge clock);
    check("t1_exec_no_valid", resp_valid, 0);
    @(negedge clock);
    check("t1_resp_valid", resp_valid, 1);
    check("t1_result", resp_result, 12);
    check("t1_id_tag", {resp_id, resp_tag}, 5'h03);
    check("t1_flags", {resp_ne, resp_lt, resp_ovf}, 3'b110);
    step();
    resp_ready = 1'b1;
    repeat (2) step();

    // Both ports valid from reset and held: grants must alternate 0,1,0,1.
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    set_req(0, 32'd100, 32'd3, 5'd1, 5'd0, 4'd10);
    set_req(1, 32'h0000_00F0, 32'h0000_0F0F, 5'd2, 5'd0, 4'd11);
    n = 0;
    while (order.size() < 4 && n < 40) begin
      @(negedge clock);
      if (rdy0) order.push_back(0);
      else if (rdy1) order.push_back(1);
      step();
      n++;
    end
    rv = 2'b00;
    check("t2_grant_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("t2_grant_order", order[i], i % 2);
    repeat (4) step();

    // Back-pressure with port 1 waiting.
    resp_ready = 1'b0;
    set_req(0, 32'd9, 32'd9, 5'd3, 5'd0, 4'd4);
    wait_accept(0, "t3_accept0");
    set_req(1, 32'd1, 32'd2, 5'd0, 5'd0, 4'd5);
    wait_resp("t3_resp_valid");
    for (int i = 0; i < 5; i++) begin
      check("t3_ready1_stall", rdy1, 0);
      step();
      @(negedge clock);
    end
    step();
    resp_ready = 1'b1;
    @(negedge clock);
    check("t3_ready1_rise", rdy1, 1);
    step();
    rv[1] = 1'b0;
    repeat (4) step();

    // Overflowing subtract and arithmetic shift.
    set_req(0, 32'h8000_0000, 32'd1, 5'd1, 5'd0, 4'd6);
    wait_accept(0, "t4_accept_sub");
    wait_resp("t4_resp_sub");
    check("t4_sub_result", resp_result, 32'h7FFF_FFFF);
    check("t4_sub_ovf_lt", {resp_ovf, resp_lt}, 2'b11);
    step();
    set_req(1, 32'hF000_0000, 32'd0, 5'd5, 5'd4, 4'd9);
    wait_accept(1, "t4_accept_sra");
    wait_resp("t4_resp_sra");
    check("t4_sra_result", resp_result, 32'hFF00_0000);
    check("t4_sra_id", resp_id, 1);
    step();
    repeat (2) step();

    // Asynchronous reset in the middle of EXEC.
    set_req(0, 32'd11, 32'd22, 5'd0, 5'd0, 4'd1);
    wait_accept(0, "t5_accept");
    #2 reset = 1'b0;
    #1;
    check("t5_rst_resp_valid", resp_valid, 0);
    check("t5_rst_alu_a", alu_a, 0);
    check("t5_rst_state", dbg_state, 0);
    set_req(0, 32'd100, 32'd50, 5'd1, 5'd0, 4'd2);
    set_req(1, 32'd7, 32'd8, 5'd0, 5'd0, 4'd8);
    @(negedge clock);
    check("t5_rst_ready", rdy, 0);
    step();
    reset = 1'b1;
    @(negedge clock);
    check("t5_first_grant", rdy, 2'b01);
    step();
    rv = 2'b00;
    repeat (4) step();

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    // Illegal opcode bypasses the ALU.
    set_req(1, 32'd1, 32'd2, 5'd7, 5'd0, 4'd6);
    wait_accept(1, "t6_accept");
    @(negedge clock);
    check("t6_resp_valid", resp_valid, 1);
    check("t6_err_result", {resp_err, resp_result}, {1'b1, 32'd0});
    check("t6_alu_op_kept", alu_op, 5'd1);
    step();
    repeat (2) step();
`endif

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      acc = rv & rdy;
      step();
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          rv[p] = 1'b0;
          ra[p] = $urandom; rb[p] = $urandom;
          rop[p] = 5'($urandom_range(0, 31)); rsh[p] = 5'($urandom_range(0, 31));
          rtag[p] = 4'($urandom_range(0, 15));
        end
        if (!rv[p] && $urandom_range(0, 2) != 0)
          set_req(p, pick(), pick(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  4'($urandom_range(0, 15)));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain outstanding responses.
    rv = 2'b00;
    resp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
